// File: rtl/if_stage_pkg.sv
// +------------------------------------------------------------------+
// | Module : if_stage_pkg                                            |
// | Brief  : shared constants and types for the instruction fetch    |
// |          stage (reset vector, NOP, FSM encodings, buffer entry).  |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
`default_nettype none

package if_stage_pkg;

    localparam logic [31:0] c_RESET_VEC  = 32'h0000_0000;
    localparam logic [31:0] c_NOP        = 32'h0000_0000;
    localparam logic [1:0]  c_IBUF_DEPTH = 2'd2;

    localparam logic [1:0]  c_ST_IDLE    = 2'd0;
    localparam logic [1:0]  c_ST_WAIT    = 2'd1;
    localparam logic [1:0]  c_ST_DROP    = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ibuf_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_ibuf.sv
// +------------------------------------------------------------------+
// | Module : if_ibuf                                                 |
// | Brief  : 2-entry fetch buffer FIFO with push/pop/flush and count. |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
`default_nettype none

module if_ibuf
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  ibuf_entry_t i_entry,
    input  logic        i_pop,
    input  logic        i_flush,
    output ibuf_entry_t o_head,
    output logic [1:0]  o_count
);

    ibuf_entry_t r_mem [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic        w_do_push;
    logic        w_do_pop;

    // A push into a full buffer is only legal when the head leaves in the same cycle
    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != c_IBUF_DEPTH) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// +------------------------------------------------------------------+
// | Module : if_stage                                                |
// | Brief  : instruction fetch stage, one outstanding memory request, |
// |          2-entry buffer, redirect with in-flight response drop.   |
// |          Optional IF_ALIGN_EXC_EN: trap misaligned redirects.     |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
`default_nettype none

module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_reg_i,
    input  logic [31:0] jump_addr_i,
    input  logic        id_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        align_err_o
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_drop_addr;
    logic [31:0] w_target;
    logic        w_halt;
    logic        w_issue;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic        w_valid;
    logic [1:0]  w_count;
    ibuf_entry_t w_head;
    ibuf_entry_t w_entry;

`ifdef IF_ALIGN_EXC_EN
    logic r_align_err;

    assign w_target = jump_addr_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_align_err <= 1'b0;
        else if (jump_reg_i && (jump_addr_i[1:0] != 2'b00))
            r_align_err <= 1'b1;
    end

    assign w_halt      = r_align_err;
    assign align_err_o = r_align_err;
`else
    assign w_target    = jump_addr_i & 32'hFFFF_FFFC;
    assign w_halt      = 1'b0;
    assign align_err_o = 1'b0;
`endif

    // The IDLE cycle that issues a request also accepts a same-cycle (zero-wait) ack
    assign w_issue  = (r_state == c_ST_IDLE) && (w_count < c_IBUF_DEPTH) && !w_halt;
    assign w_accept = imem_ack_i && (w_issue || (r_state == c_ST_WAIT));
    assign w_push   = w_accept && !jump_reg_i;
    assign w_valid  = (w_count != 2'd0);
    assign w_pop    = w_valid && id_ready_i && !jump_reg_i;
    assign w_entry  = '{pc: r_fetch_pc, inst: imem_rdata_i};

    if_ibuf u_ibuf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_flush (jump_reg_i),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_issue && !imem_ack_i)
                    w_state_nxt = jump_reg_i ? c_ST_DROP : c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (imem_ack_i)
                    w_state_nxt = c_ST_IDLE;
                else if (jump_reg_i)
                    w_state_nxt = c_ST_DROP;
            end
            c_ST_DROP: begin
                if (imem_ack_i)
                    w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // r_drop_addr freezes on DROP entry so the abandoned request stays stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc  <= c_RESET_VEC;
            r_drop_addr <= c_RESET_VEC;
        end else begin
            if (jump_reg_i)
                r_fetch_pc <= w_target;
            else if (w_push)
                r_fetch_pc <= r_fetch_pc + 32'd4;
            if (r_state != c_ST_DROP)
                r_drop_addr <= r_fetch_pc;
        end
    end

    always_comb begin
        imem_req_o  = !rst && (w_issue || (r_state != c_ST_IDLE));
        imem_addr_o = (r_state == c_ST_DROP) ? r_drop_addr : r_fetch_pc;
        valid_o     = w_valid;
        pc_o        = w_valid ? w_head.pc   : r_fetch_pc;
        inst_o      = w_valid ? w_head.inst : c_NOP;
    end

endmodule

`default_nettype wire
